// File: rtl/fpu_pkg.sv
// Shared types for the FPU arithmetic blocks.
package fpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } serial_adder_state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder made from two half adders; the carries can never both be high, so OR merges them.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic Ci,
   output logic S,
   output logic Co
);

   logic s1;
   logic c1;
   logic c2;

   half_adder u_ha0 (
      .A (A),
      .B (B),
      .S (s1),
      .C (c1)
   );

   half_adder u_ha1 (
      .A (s1),
      .B (Ci),
      .S (S),
      .C (c2)
   );

   assign Co = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder: sum and carry of two bits.
module half_adder (
   input  logic A,
   input  logic B,
   output logic S,
   output logic C
);

   assign S = A ^ B;
   assign C = A & B;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, WIDTH cycles per operation.
module serial_adder
   import fpu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Co
);

   localparam int CntW = $clog2(WIDTH + 1);

   serial_adder_state_t state_q, state_d;

   logic [WIDTH-1:0] aSr_q, aSr_d;
   logic [WIDTH-1:0] bSr_q, bSr_d;
   logic [WIDTH-1:0] sSr_q, sSr_d;
   logic             carry_q, carry_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             co_q, co_d;

   logic             faS;
   logic             faCo;
   logic             lastBit;
   logic [WIDTH-1:0] sShift;

   full_adder u_fa (
      .A  (aSr_q[0]),
      .B  (bSr_q[0]),
      .Ci (carry_q),
      .S  (faS),
      .Co (faCo)
   );

   assign lastBit = (count_q == CntW'(WIDTH - 1));
   // New sum bit enters at the MSB; the bit dropped off the bottom is never needed.
   assign sShift  = WIDTH'({faS, sSr_q} >> 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (lastBit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   always_comb begin
      aSr_d   = aSr_q;
      bSr_d   = bSr_q;
      sSr_d   = sSr_q;
      carry_d = carry_q;
      count_d = count_q;
      sum_d   = sum_q;
      co_d    = co_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               aSr_d   = A;
               bSr_d   = B;
               carry_d = Cin;
               count_d = '0;
               sSr_d   = '0;
            end
         end
         RUN: begin
            aSr_d   = aSr_q >> 1;
            bSr_d   = bSr_q >> 1;
            sSr_d   = sShift;
            carry_d = faCo;
            count_d = count_q + CntW'(1);
            // The result registers only move on the final bit, so they hold the last answer meanwhile.
            if (lastBit) begin
               sum_d = sShift;
               co_d  = faCo;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aSr_q   <= '0;
         bSr_q   <= '0;
         sSr_q   <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
      end else begin
         aSr_q   <= aSr_d;
         bSr_q   <= bSr_d;
         sSr_q   <= sSr_d;
         carry_q <= carry_d;
         count_q <= count_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
      end
   end

   assign S  = sum_q;
   assign Co = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1 with hand-computed vectors.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;

   logic       start8;
   logic [7:0] A8, B8;
   logic       Cin8;
   logic       busy8, done8, Co8;
   logic [7:0] S8;

   logic       start1;
   logic [0:0] A1, B1;
   logic       Cin1;
   logic       busy1, done1, Co1;
   logic [0:0] S1;

   int total = 0;
   int bad = 0;
   int dones8 = 0;
   int dones1 = 0;
   int issued8 = 0;
   int issued1 = 0;

   logic [8:0] exp8[$];
   logic [1:0] exp1[$];

   serial_adder #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .A     (A8),
      .B     (B8),
      .Cin   (Cin8),
      .busy  (busy8),
      .done  (done8),
      .S     (S8),
      .Co    (Co8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .A     (A1),
      .B     (B1),
      .Cin   (Cin1),
      .busy  (busy1),
      .done  (done1),
      .S     (S1),
      .Co    (Co1)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: every done pulse pops the oldest expected result for that instance.
   always @(negedge clk) begin
      if (!rst && done8) begin
         dones8++;
         if (exp8.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL result8: got done with 0x%0h, want no done", {Co8, S8});
         end else begin
            checkOutput("result8", {Co8, S8}, exp8.pop_front());
         end
      end
      if (!rst && done1) begin
         dones1++;
         if (exp1.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL result1: got done with 0x%0h, want no done", {Co1, S1});
         end else begin
            checkOutput("result1", {7'd0, Co1, S1}, {7'd0, exp1.pop_front()});
         end
      end
   end

   // Issues one operation and checks busy length, done latency and that the old result is held.
   task automatic applyStimulus(input bit wide, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic [8:0] expected,
                                input logic [8:0] held, input bit pulse);
      int w;
      int busyCnt;
      int earlyDone;
      w = wide ? 8 : 1;
      busyCnt = 0;
      earlyDone = 0;
      @(negedge clk);
      if (wide) begin
         A8 = a; B8 = b; Cin8 = cin; start8 = 1'b1;
         exp8.push_back(expected);
         issued8++;
      end else begin
         A1 = a[0:0]; B1 = b[0:0]; Cin1 = cin; start1 = 1'b1;
         exp1.push_back(expected[1:0]);
         issued1++;
      end
      @(posedge clk);
      #1;
      start8 = 1'b0;
      start1 = 1'b0;
      A8 = 8'hC3; B8 = 8'h3C; Cin8 = 1'b1;
      A1 = ~a[0:0]; B1 = ~b[0:0]; Cin1 = ~cin;
      for (int k = 0; k < w; k++) begin
         @(negedge clk);
         busyCnt += wide ? int'(busy8) : int'(busy1);
         earlyDone += wide ? int'(done8) : int'(done1);
         if (k == w - 1)
            checkOutput("heldResult", wide ? {Co8, S8} : {7'd0, Co1, S1}, held);
         if (pulse && k == 1) begin
            A8 = 8'hFF; B8 = 8'hFF; Cin8 = 1'b1; start8 = 1'b1;
         end
         if (pulse && k == 2) start8 = 1'b0;
      end
      @(negedge clk);
      checkOutput("doneLatency", {8'd0, wide ? done8 : done1}, 9'd1);
      checkOutput("busyInDone", {8'd0, wide ? busy8 : busy1}, 9'd0);
      checkOutput("busyCycles", 9'(busyCnt), 9'(w));
      checkOutput("noEarlyDone", 9'(earlyDone), 9'd0);
      if (pulse) begin
         A8 = 8'h01; B8 = 8'h01; start8 = 1'b1;
         @(posedge clk);
         #1;
         start8 = 1'b0;
      end
   endtask

   logic [3:0] vec1[8];

   initial begin
      logic [8:0] held1;
      rst = 1'b1;
      start8 = 1'b0; A8 = '0; B8 = '0; Cin8 = 1'b0;
      start1 = 1'b0; A1 = '0; B1 = '0; Cin1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      start8 = 1'b1;
      @(negedge clk);
      checkOutput("resetBusy8", {8'd0, busy8}, 9'd0);
      checkOutput("resetDone8", {8'd0, done8}, 9'd0);
      checkOutput("resetResult8", {Co8, S8}, 9'h000);
      checkOutput("resetResult1", {7'd0, Co1, S1}, 9'h000);
      start8 = 1'b0;
      rst = 1'b0;

      $display("[TB] WIDTH=8 directed vectors");
      applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 9'h000, 9'h000, 1'b0);
      applyStimulus(1'b1, 8'hFF, 8'h01, 1'b0, 9'h100, 9'h000, 1'b0);
      applyStimulus(1'b1, 8'h7F, 8'h80, 1'b0, 9'h0FF, 9'h100, 1'b0);
      applyStimulus(1'b1, 8'hA5, 8'h5A, 1'b1, 9'h100, 9'h0FF, 1'b0);
      applyStimulus(1'b1, 8'h33, 8'h11, 1'b0, 9'h044, 9'h100, 1'b1);
      repeat (12) @(negedge clk);
      checkOutput("singleDone8", 9'(dones8), 9'(issued8));

      $display("[TB] reset in the middle of RUN");
      @(negedge clk);
      A8 = 8'h0F; B8 = 8'h01; Cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("busyBeforeReset", {8'd0, busy8}, 9'd1);
      rst = 1'b1;
      start8 = 1'b1;
      A8 = 8'hFF; B8 = 8'hFF;
      @(negedge clk);
      checkOutput("midResetBusy", {8'd0, busy8}, 9'd0);
      checkOutput("midResetDone", {8'd0, done8}, 9'd0);
      checkOutput("midResetResult", {Co8, S8}, 9'h000);
      rst = 1'b0;
      start8 = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("noDoneAfterReset", 9'(dones8), 9'(issued8));
      applyStimulus(1'b1, 8'h10, 8'h20, 1'b0, 9'h030, 9'h000, 1'b0);

      $display("[TB] WIDTH=1 exhaustive vectors");
      // {A, B, Cin, expected {Co,S}} packed as a,b,cin in [3:1]; expected computed by hand below
      vec1[0] = 4'b0000; vec1[1] = 4'b0010; vec1[2] = 4'b0100; vec1[3] = 4'b0110;
      vec1[4] = 4'b1000; vec1[5] = 4'b1010; vec1[6] = 4'b1100; vec1[7] = 4'b1110;
      held1 = 9'h000;
      for (int i = 0; i < 8; i++) begin
         logic [8:0] want;
         case (i)
            0: want = 9'd0;
            1: want = 9'd1;
            2: want = 9'd1;
            3: want = 9'd2;
            4: want = 9'd1;
            5: want = 9'd2;
            6: want = 9'd2;
            default: want = 9'd3;
         endcase
         applyStimulus(1'b0, {7'd0, vec1[i][3]}, {7'd0, vec1[i][2]}, vec1[i][1], want, held1, 1'b0);
         held1 = want;
      end
      repeat (4) @(negedge clk);
      checkOutput("doneCount1", 9'(dones1), 9'(issued1));
      checkOutput("doneCount8", 9'(dones8), 9'(issued8));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
